coder_n_scan: RTL
=================

# coder_n_scan

Parametrised, registered binary-to-one-hot decoder, the successor to the 2-to-4 combinational coder. It generalises the index width and adds thermometer decoding, an auto-scan mode with a programmable step period, an enable/freeze input and a load/valid handshake. It sits between control logic and multiplexed outputs such as digit or LED scan lines and row selects.

## Interface
Parameters:
- IDX_W, default 2: index width; output width is OUT_W = 2**IDX_W (legal 1..5).
- SCAN_DIV, default 4: clock cycles per scan step (legal ≥1).

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset. Asserts immediately; released synchronously to clk externally.
- en, input, 1: when 0, all registers hold, including the prescaler. load is ignored.
- mode, input, 2: 00 DIRECT, 01 THERMO, 10 SCAN, 11 OFF; sampled every enabled cycle.
- index, input, IDX_W: binary index, sampled only when load=1.
- load, input, 1: one-cycle strobe requesting decode of index (DIRECT/THERMO only).
- result, output, OUT_W: registered decoded output.
- valid, output, 1: one-cycle pulse; result was just updated by a load.
- scan_idx, output, IDX_W: current scan pointer (binary).
- scan_tick, output, 1: one-cycle pulse; result just advanced in SCAN.

## Operation
- Reset values: result=0, valid=0, scan_idx=0, scan_tick=0, prescaler=0, prev_mode=OFF.
- DIRECT: on an enabled cycle with load=1, result ← 1<<index (index 1 → 0b0010 for IDX_W=2); valid=1 next cycle. Without load, result holds.
- THERMO: on an enabled cycle with load=1, result bits [index:0] set and others cleared (index 2 → 0b0111); valid=1 next cycle.
- SCAN entry (mode=10, prev_mode≠10): prescaler ← 0, scan_idx ← 0, result ← 1; scan_tick=1 on that update.
- SCAN steady state: the prescaler counts 0..SCAN_DIV-1. On wrap, scan_idx ← scan_idx+1 mod OUT_W, result ← 1<<(new scan_idx), scan_tick=1. load is ignored and valid stays 0.
- OFF: result ← 0 next cycle. valid and scan_tick stay 0. scan_idx holds.
- Leaving SCAN: the prescaler stops. result holds until the next load (DIRECT/THERMO) or cleared (OFF).
- Mode change and load in the same cycle: the new mode governs the load (mode=10 discards it; mode=11 clears result with no valid).
- prev_mode updates only on enabled cycles, so toggling en does not re-trigger SCAN entry.

## Timing
- DIRECT/THERMO latency: 1 cycle from the load edge to result and valid. Back-to-back loads produce back-to-back valid pulses.
- SCAN: first step on the edge after mode becomes 10. Each later step comes exactly SCAN_DIV enabled cycles after the previous one. SCAN_DIV=1 steps every cycle.
- Wrap: scan_idx goes OUT_W-1 → 0 with no gap cycle.
- en=0 mid-period: the prescaler freezes. The remaining count resumes when en returns, so the step period counts enabled cycles only.
- rst mid-scan: outputs clear immediately. After release the block is in OFF state and SCAN re-entry is required.
- Pulse behaviour: valid and scan_tick are never high simultaneously. Each pulse is cleared on the next edge unless re-asserted.

## Structure
- Package coder_pkg holds the mode constants MODE_DIRECT, MODE_THERMO, MODE_SCAN and MODE_OFF, plus the 2-bit mode_t typedef.
- Sub-module scan_prescaler, parametrised by SCAN_DIV:
  - inputs clk, rst, en, clear;
  - output tick;
  - counter width $clog2(SCAN_DIV), minimum 1.
- Top level holds the mode register, scan pointer and output registers. The decode is a shift/mask, not a case table, so it scales with IDX_W.

## Test plan
With IDX_W=2 and SCAN_DIV=3 unless noted:
- Reset/DIRECT: assert rst → result=0000, valid=0. Then mode=00, load with index=0,1,2,3 on consecutive cycles → result 0001, 0010, 0100, 1000 one cycle after each load; valid high 4 cycles.
- THERMO: mode=01, load index=2 → result=0111 and a valid pulse. Then load index=0 → result=0001.
- SCAN: mode=10 → result=0001 and scan_tick next edge. Then 0010, 0100, 1000, 0001 every 3 cycles; scan_idx wraps 3→0. With SCAN_DIV=1, result steps every cycle.
- Freeze: in SCAN, drop en for 5 cycles mid-period → no change. The step arrives after the remaining enabled cycles; load during en=0 produces no valid.
- Simultaneous events: mode 00→10 with load=1, index=3 → result=0001, no valid. Mode →11 with load → result=0000, no valid.
- Reset mid-operation: assert rst asynchronously between edges during SCAN → result, scan_idx and scan_tick are 0 before the next edge.

Source files
------------

// File: rtl/coder_pkg.sv
// ---------------------------------------------------------------------------
// coder_pkg
// Shared definitions for the coder_n_scan decoder block.
//   mode_t      : 2-bit operating mode (DIRECT, THERMO, SCAN, OFF)
//   MODE_*      : mode encodings as seen on the mode input
// ---------------------------------------------------------------------------
package coder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

endpackage : coder_pkg

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Step-period counter for the auto-scan mode. Counts enabled cycles
// 0..SCAN_DIV-1 and flags the wrap cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (counter -> 0)
//   en    : count enable; counter holds when low
//   clear : restart the period at 0 (takes priority over en)
//   tick  : high in the enabled cycle in which the counter wraps
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Combinational so the top can advance the pointer on the same edge
    // that wraps the counter.
    assign tick = en && !clear && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : scan_prescaler

// File: rtl/coder_n_scan.sv
// ---------------------------------------------------------------------------
// coder_n_scan
// Registered binary-to-one-hot / thermometer decoder with an auto-scan mode.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : enable; when low every register holds (pulses drop)
//   mode      : 00 DIRECT, 01 THERMO, 10 SCAN, 11 OFF
//   index     : binary index, used when load=1
//   load      : one-cycle decode request (DIRECT/THERMO only)
//   result    : registered decoded output, OUT_W = 2**IDX_W bits
//   valid     : one-cycle pulse, result updated by a load
//   scan_idx  : current scan pointer
//   scan_tick : one-cycle pulse, result advanced by the scanner
// Handshake: load is a strobe with no back-pressure; every enabled load in
// DIRECT/THERMO is answered by exactly one valid pulse on the next edge.
// ---------------------------------------------------------------------------
module coder_n_scan
    import coder_pkg::*;
#(
    parameter int IDX_W    = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [IDX_W-1:0]      index,
    input  logic                  load,
    output logic [(2**IDX_W)-1:0] result,
    output logic                  valid,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  scan_tick
);

    localparam int OUT_W = 2 ** IDX_W;
    localparam logic [OUT_W-1:0] ALL_ONES = '1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(OUT_W - 1);

    mode_t            mode_s;
    mode_t            prev_mode_q, prev_mode_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic             scan_tick_q, scan_tick_d;

    logic             scan_entry;
    logic             scan_run;
    logic             pre_tick;
    logic [IDX_W-1:0] scan_idx_inc;
    logic [OUT_W-1:0] onehot_load;
    logic [OUT_W-1:0] thermo_load;
    logic [OUT_W-1:0] onehot_scan;

    assign mode_s = mode_t'(mode);

    // Entry is detected against the mode of the last enabled cycle, so
    // toggling en while in SCAN never restarts the scan.
    assign scan_entry = en && (mode_s == MODE_SCAN) && (prev_mode_q != MODE_SCAN);
    assign scan_run   = en && (mode_s == MODE_SCAN) && (prev_mode_q == MODE_SCAN);

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (scan_run),
        .clear (scan_entry),
        .tick  (pre_tick)
    );

    // Shift/mask decode so the width scales with IDX_W.
    assign scan_idx_inc = scan_idx_q + IDX_W'(1);
    assign onehot_load  = OUT_W'(1) << index;
    assign thermo_load  = ALL_ONES >> (IDX_MAX - index);
    assign onehot_scan  = OUT_W'(1) << scan_idx_inc;

    always_comb begin
        prev_mode_d = prev_mode_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        scan_idx_d  = scan_idx_q;
        scan_tick_d = 1'b0;
        if (en) begin
            prev_mode_d = mode_s;
            unique case (mode_s)
                MODE_DIRECT: begin
                    if (load) begin
                        result_d = onehot_load;
                        valid_d  = 1'b1;
                    end
                end
                MODE_THERMO: begin
                    if (load) begin
                        result_d = thermo_load;
                        valid_d  = 1'b1;
                    end
                end
                MODE_SCAN: begin
                    if (scan_entry) begin
                        scan_idx_d  = '0;
                        result_d    = OUT_W'(1);
                        scan_tick_d = 1'b1;
                    end else if (pre_tick) begin
                        // Pointer wraps OUT_W-1 -> 0 by natural overflow.
                        scan_idx_d  = scan_idx_inc;
                        result_d    = onehot_scan;
                        scan_tick_d = 1'b1;
                    end
                end
                MODE_OFF: begin
                    result_d = '0;
                end
                default: begin
                    result_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mode_q <= MODE_OFF;
            result_q    <= '0;
            valid_q     <= 1'b0;
            scan_idx_q  <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            prev_mode_q <= prev_mode_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            scan_idx_q  <= scan_idx_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign result    = result_q;
    assign valid     = valid_q;
    assign scan_idx  = scan_idx_q;
    assign scan_tick = scan_tick_q;

endmodule : coder_n_scan
